// File: rtl/dcache_wt.sv
// Direct-mapped, write-through, no-write-allocate L1 data cache with one-word lines.
// Latency: load hit 2 cycles (request edge to cpu_ready); misses/stores add memory wait + 1.
// Backpressure: one request in flight; cpu_req is only sampled in IDLE. Optional DCACHE_WT_STATS_EN adds hit/miss counters.
module dcache_wt #(
    parameter int LINES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [2:0]  cpu_mask,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_ready,
    output logic        mem_rd_en,
    output logic        mem_wr_en,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [2:0]  mem_mask,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
`ifdef DCACHE_WT_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = 30 - IDX_W;

    typedef enum logic [2:0] {IDLE, LOOKUP, MEM_RD, MEM_WR, RESP} state_t;

    state_t state, state_nxt;

    // Request operands captured in IDLE; the core holds them but we do not rely on it.
    logic        r_we;
    logic [2:0]  r_mask;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;

    logic [LINES-1:0] valid;
    logic [TAG_W-1:0] tag_mem  [LINES];
    logic [31:0]      data_mem [LINES];

    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic             hit;
    logic             mask_ok;

    assign idx     = r_addr[IDX_W+1:2];
    assign tag     = r_addr[31:IDX_W+2];
    assign hit     = valid[idx] && (tag_mem[idx] == tag);
    assign mask_ok = (r_mask == 3'b000) || (r_mask == 3'b001) || (r_mask == 3'b010) ||
                     (r_mask == 3'b100) || (r_mask == 3'b101);

    // Next values of every registered output
    logic        ready_nxt;
    logic [31:0] rdata_nxt;
    logic        rd_nxt;
    logic        wr_nxt;
    logic [31:0] maddr_nxt;
    logic [31:0] mwdata_nxt;
    logic [2:0]  mmask_nxt;
    logic        line_we;
    logic        line_fill;
    logic [31:0] line_wdata;

    // Load-side lane selection and sign/zero extension, identical to what memory returns.
    function automatic logic [31:0] extract(input logic [31:0] w, input logic [2:0] m,
                                            input logic [1:0] lane);
        logic [7:0]  b;
        logic [15:0] h;
        case (lane)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = lane[1] ? w[31:16] : w[15:0];
        case (m)
            3'b000:  extract = {{24{b[7]}}, b};
            3'b100:  extract = {24'd0, b};
            3'b001:  extract = {{16{h[15]}}, h};
            3'b101:  extract = {16'd0, h};
            3'b010:  extract = w;
            default: extract = 32'd0;
        endcase
    endfunction

    // Store-hit byte merge; size comes from the low mask bits (signedness is irrelevant for stores).
    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [1:0] sz, input logic [1:0] lane);
        merge = old;
        case (sz)
            2'b00: begin
                case (lane)
                    2'd0:    merge[7:0]   = wd[7:0];
                    2'd1:    merge[15:8]  = wd[7:0];
                    2'd2:    merge[23:16] = wd[7:0];
                    default: merge[31:24] = wd[7:0];
                endcase
            end
            2'b01: begin
                if (lane[1]) merge[31:16] = wd[15:0];
                else         merge[15:0]  = wd[15:0];
            end
            default: merge = wd;
        endcase
    endfunction

    // Next-state, output and line-update decisions
    always_comb begin
        state_nxt  = state;
        ready_nxt  = 1'b0;
        rdata_nxt  = cpu_rdata;
        rd_nxt     = 1'b0;
        wr_nxt     = 1'b0;
        maddr_nxt  = mem_addr;
        mwdata_nxt = mem_wdata;
        mmask_nxt  = mem_mask;
        line_we    = 1'b0;
        line_fill  = 1'b0;
        line_wdata = data_mem[idx];
        case (state)
            IDLE: begin
                if (cpu_req) state_nxt = LOOKUP;
            end
            LOOKUP: begin
                if (!mask_ok) begin
                    state_nxt = RESP;
                    ready_nxt = 1'b1;
                    rdata_nxt = 32'd0;
                end else if (r_we) begin
                    state_nxt  = MEM_WR;
                    wr_nxt     = 1'b1;
                    maddr_nxt  = r_addr;
                    mwdata_nxt = r_wdata;
                    mmask_nxt  = r_mask;
                    line_we    = hit;
                    line_wdata = merge(data_mem[idx], r_wdata, r_mask[1:0], r_addr[1:0]);
                end else if (hit) begin
                    state_nxt = RESP;
                    ready_nxt = 1'b1;
                    rdata_nxt = extract(data_mem[idx], r_mask, r_addr[1:0]);
                end else begin
                    state_nxt = MEM_RD;
                    rd_nxt    = 1'b1;
                    maddr_nxt = {r_addr[31:2], 2'b00};
                    mmask_nxt = 3'b010;
                end
            end
            MEM_RD: begin
                if (mem_ready) begin
                    state_nxt  = RESP;
                    ready_nxt  = 1'b1;
                    rdata_nxt  = extract(mem_rdata, r_mask, r_addr[1:0]);
                    line_we    = 1'b1;
                    line_fill  = 1'b1;
                    line_wdata = mem_rdata;
                end else begin
                    rd_nxt = 1'b1;
                end
            end
            MEM_WR: begin
                if (mem_ready) begin
                    state_nxt = RESP;
                    ready_nxt = 1'b1;
                end else begin
                    wr_nxt = 1'b1;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, registered outputs, request latch and valid bits
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cpu_ready <= 1'b0;
            cpu_rdata <= 32'd0;
            mem_rd_en <= 1'b0;
            mem_wr_en <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
            mem_mask  <= 3'b010;
            r_we      <= 1'b0;
            r_mask    <= 3'b010;
            r_addr    <= 32'd0;
            r_wdata   <= 32'd0;
            valid     <= '0;
        end else begin
            state     <= state_nxt;
            cpu_ready <= ready_nxt;
            cpu_rdata <= rdata_nxt;
            mem_rd_en <= rd_nxt;
            mem_wr_en <= wr_nxt;
            mem_addr  <= maddr_nxt;
            mem_wdata <= mwdata_nxt;
            mem_mask  <= mmask_nxt;
            if (state == IDLE && cpu_req) begin
                r_we    <= cpu_we;
                r_mask  <= cpu_mask;
                r_addr  <= cpu_addr;
                r_wdata <= cpu_wdata;
            end
            if (line_fill) valid[idx] <= 1'b1;
        end
    end

    // Tag and data arrays; validity alone guards them, so they need no reset.
    always_ff @(posedge clk) begin
        if (line_we && !reset)   data_mem[idx] <= line_wdata;
        if (line_fill && !reset) tag_mem[idx]  <= tag;
    end

`ifdef DCACHE_WT_STATS_EN
    // Saturating hit/miss counters, one increment per supported lookup
    always_ff @(posedge clk) begin
        if (reset) begin
            hit_count  <= 32'd0;
            miss_count <= 32'd0;
        end else if (state == LOOKUP && mask_ok) begin
            if (hit) begin
                if (hit_count != 32'hFFFF_FFFF) hit_count <= hit_count + 32'd1;
            end else begin
                if (miss_count != 32'hFFFF_FFFF) miss_count <= miss_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/dcache_wt.md
# dcache_wt

Direct-mapped, write-through, no-write-allocate L1 data cache with one-word lines, placed between a core's load/store stage and the shared data memory port. It accepts one load or store at a time from the core, serves read hits locally, and forwards every store and every read miss to memory. It also applies the memory's byte-lane and sign/zero-extension rules on cached reads, so the core sees identical data with or without the cache.

## Interface
- `LINES`, 64: number of one-word lines; power of two, ≥2. `IDX_W = log2(LINES)`.
- `clk` in 1: single clock; all state updates on posedge.
- `reset` in 1: synchronous, active-high.
- `cpu_req` in 1: request valid; held with operands stable until `cpu_ready`.
- `cpu_we` in 1: 1 = store, 0 = load.
- `cpu_mask` in 3: 000 byte, 001 half, 010 word, 100 byte unsigned, 101 half unsigned.
- `cpu_addr` in 32: byte address.
- `cpu_wdata` in 32: store data, right-aligned.
- `cpu_rdata` out 32: load result, valid while `cpu_ready`=1.
- `cpu_ready` out 1: one-cycle completion pulse.
- `mem_rd_en`, `mem_wr_en` out 1: memory read / write request, held until `mem_ready`.
- `mem_addr` out 32, `mem_wdata` out 32, `mem_mask` out 3: memory request operands.
- `mem_rdata` in 32: raw word, sampled when `mem_ready`=1 during a read.
- `mem_ready` in 1: memory completion, one cycle.

## Operation
- Address split: index = `addr[IDX_W+1:2]`, tag = `addr[31:IDX_W+2]`, lane = `addr[1:0]`. Each line holds a valid bit, a tag and 32 data bits.
- FSM states: IDLE, LOOKUP, MEM_RD, MEM_WR, RESP.
- IDLE: when `cpu_req`=1, latch we/mask/addr/wdata and go to LOOKUP. `cpu_req` is ignored in all other states.
- LOOKUP: hit = valid[index] && tag match.
  - Unsupported mask (011, 110, 111): go to RESP with rdata 0. No memory traffic, no cache update.
  - Load hit: go to RESP with extracted data.
  - Load miss: go to MEM_RD.
  - Store: on a hit, byte-merge into the line (sb replaces lane `addr[1:0]`, sh replaces half `addr[1]`, sw replaces the whole word). Hit or miss, go to MEM_WR. Misses are not allocated.
- MEM_RD: `mem_rd_en`=1, `mem_addr`={`addr[31:2]`,2'b00}, `mem_mask`=010. On `mem_ready`, fill the line (valid=1, tag, `mem_rdata`), then go to RESP with data extracted from `mem_rdata`.
- MEM_WR: `mem_wr_en`=1, `mem_addr`=`cpu_addr`, `mem_mask`=`cpu_mask`, `mem_wdata`=`cpu_wdata`. Memory performs its own read-modify-write. On `mem_ready`, go to RESP.
- RESP: `cpu_ready`=1 for exactly one cycle, then IDLE.
- Load extraction:
  - Byte: lane `addr[1:0]`.
  - Half: `addr[1]` selects bits [15:0] or [31:16].
  - Signed masks sign-extend; unsigned masks zero-extend; word returns the full word.
- Misaligned half/word loads and stores ignore the low address bits as listed above; no exception is raised.

## Timing
- All outputs are registered.
- Reset values: `cpu_ready`=0, `cpu_rdata`=0, `mem_rd_en`=0, `mem_wr_en`=0, `mem_addr`=0, `mem_wdata`=0, `mem_mask`=010, state=IDLE, all valid bits 0.
- Load hit: request sampled at edge 0; `cpu_ready` high in the cycle after edge 1 (two-cycle latency).
- Load miss and stores: LOOKUP, then memory cycles until `mem_ready`, then a one-cycle RESP. Memory request outputs drop in the cycle after `mem_ready` is sampled.
- Back-to-back: the next request is accepted no earlier than the cycle after the `cpu_ready` cycle.
- `mem_ready` is ignored outside MEM_RD and MEM_WR.
- Reset is sampled at any state, including mid-MEM_RD/MEM_WR. On the next cycle all outputs take reset values and all lines are invalid. A pending memory transaction is abandoned and the line is not filled.

## Configuration
- `DCACHE_WT_STATS_EN`
  - Defined: adds outputs `hit_count` (32) and `miss_count` (32), reset to 0, saturating at 0xFFFFFFFF.
  - Each LOOKUP with a supported mask increments exactly one counter: loads and stores are both counted, and a store hit counts as a hit.
  - Undefined: ports and counters are absent; behaviour is otherwise identical.

## Test plan
- Reset, then lw 0x100: `mem_rd_en`=1 with `mem_addr`=0x100; memory returns 0xDEADBEEF; `cpu_rdata`=0xDEADBEEF. Repeat lw 0x100: no `mem_rd_en`, `cpu_ready` two cycles after request.
- Line 0x200 holds 0x80FF0000: lb 0x203 → 0xFFFFFF80; lbu 0x203 → 0x00000080; lh 0x202 → 0xFFFF80FF; lhu 0x200 → 0x00000000.
- Line 0x100 holds 0xDEADBEEF: sb 0x101 wdata 0x55 → `mem_wr_en` with mask 000 and addr 0x101; then lw 0x100 hits and returns 0xDEAD55EF with no memory read.
- LINES=64: lw 0x000 then lw 0x100 (both index 0) both miss; lw 0x000 then misses again.
- sw 0x300 wdata 0x12345678 on an invalid line → one memory write; following lw 0x300 misses (no allocate).
- Reset asserted while MEM_RD waits with `mem_ready`=0 → next cycle `mem_rd_en`=0, state IDLE; lw 0x100 then misses.
